// File: rtl/pixel_commit_buffer.sv
// Pixel draw-stream sink: FIFO, bounds check, row-major addressing and full-screen clear.
// Optional transparent-colour skipping is enabled by defining PIXEL_COMMIT_CHROMA_KEY_EN.
module pixel_commit_buffer #(
    parameter int         FIFO_DEPTH   = 16,
    parameter int         SCREEN_W     = 320,
    parameter int         SCREEN_H     = 240,
    parameter int         ADDR_W       = 17,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000,
    parameter logic [2:0] KEY_COLOUR   = 3'b111
) (
    input  logic              clock_all,
    input  logic              reset_all,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [8:0]        in_x,
    input  logic [7:0]        in_y,
    input  logic [2:0]        in_colour,
    input  logic              clear_req,
    input  logic              fb_grant,
    output logic [ADDR_W-1:0] fb_address,
    output logic [2:0]        fb_data,
    output logic              fb_wren,
    output logic              dropped,
    output logic              busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]       DEPTH_C    = (PW+1)'(FIFO_DEPTH);
    localparam logic [8:0]        W_LIM      = 9'(SCREEN_W);
    localparam logic [7:0]        H_LIM      = 8'(SCREEN_H);
    localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(SCREEN_W * SCREEN_H - 1);

`ifdef PIXEL_COMMIT_CHROMA_KEY_EN
    localparam logic CHROMA_EN = 1'b1;
`else
    localparam logic CHROMA_EN = 1'b0;
`endif

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [19:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic [0:0]        state;
    logic              clear_pending;
    logic [ADDR_W-1:0] sweep;

    logic              p_valid;
    logic [8:0]        p_x;
    logic [7:0]        p_y;
    logic [2:0]        p_colour;

    logic              push, pop, in_bounds, key_hit;
    logic [ADDR_W-1:0] p_addr;

    assign in_ready  = (count < DEPTH_C) && !clear_pending && (state != CLEAR);
    assign push      = in_valid && in_ready;
    assign pop       = (state == RUN) && (count != '0) && fb_grant;
    assign busy      = (count != '0) || clear_pending || (state == CLEAR) || p_valid;

    // y*320 + x as shift-add, evaluated on the staged entry
    assign in_bounds = (p_x < W_LIM) && (p_y < H_LIM);
    assign key_hit   = CHROMA_EN && (p_colour == KEY_COLOUR);
    assign p_addr    = ADDR_W'({p_y, 8'b0}) + ADDR_W'({p_y, 6'b0}) + ADDR_W'(p_x);

    always_ff @(posedge clock_all) begin
        if (push)
            mem[wr_ptr] <= {in_x, in_y, in_colour};
    end

    always_ff @(posedge clock_all or posedge reset_all) begin
        if (reset_all) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            state         <= RUN;
            clear_pending <= 1'b0;
            sweep         <= '0;
            p_valid       <= 1'b0;
            p_x           <= '0;
            p_y           <= '0;
            p_colour      <= '0;
            fb_wren       <= 1'b0;
            fb_address    <= '0;
            fb_data       <= '0;
            dropped       <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            p_valid <= pop;
            if (pop)
                {p_x, p_y, p_colour} <= mem[rd_ptr];

            if (clear_req && state != CLEAR)
                clear_pending <= 1'b1;

            fb_wren <= 1'b0;
            dropped <= 1'b0;

            if (state == RUN) begin
                // sweep starts only once every queued pixel has left the pipeline
                if (clear_pending && count == '0 && !p_valid)
                    state <= CLEAR;
                if (p_valid) begin
                    if (!in_bounds) begin
                        dropped <= 1'b1;
                    end else if (!key_hit) begin
                        fb_wren    <= 1'b1;
                        fb_address <= p_addr;
                        fb_data    <= p_colour;
                    end
                end
            end else if (fb_grant) begin
                fb_wren    <= 1'b1;
                fb_address <= sweep;
                fb_data    <= CLEAR_COLOUR;
                if (sweep == SWEEP_LAST) begin
                    sweep         <= '0;
                    state         <= RUN;
                    clear_pending <= 1'b0;
                end else begin
                    sweep <= sweep + 1'b1;
                end
            end
        end
    end

endmodule
